// File: rtl/karatsuba_mul16_seq.sv
// Sequential unsigned W x W multiplier using one Karatsuba step.
// The three sub-products are formed one per cycle on a single shared
// (H+1)x(H+1) multiplier and recombined into a 2W-bit product.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for an operand pair; halves captured on accept
// LO    | z0 = al * bl
// HI    | z2 = ah * bh
// MID   | zm = (ah + al) * (bh + bl)
// COMB  | z1 = zm - z2 - z0; p = z2<<W + z1<<H + z0
// DONE  | product presented, held until out_ready
module karatsuba_mul16_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

    localparam int H  = W / 2;
    localparam int HP = H + 1;
    localparam int MW = 2 * H + 2;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        MID  = 3'd3,
        COMB = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t          state;

    logic [H-1:0]    ah;
    logic [H-1:0]    al;
    logic [H-1:0]    bh;
    logic [H-1:0]    bl;
    logic [HP-1:0]   sa;
    logic [HP-1:0]   sb;

    logic [2*H-1:0]  z0;
    logic [2*H-1:0]  z2;
    logic [MW-1:0]   zm;

    logic [HP-1:0]   mul_a;
    logic [HP-1:0]   mul_b;
    logic [MW-1:0]   mul_out;

    logic [MW-1:0]   z1;
    logic [PW-1:0]   p_next;

    // Route the shared multiplier's operands according to the current phase.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            LO: begin
                mul_a = {1'b0, al};
                mul_b = {1'b0, bl};
            end
            HI: begin
                mul_a = {1'b0, ah};
                mul_b = {1'b0, bh};
            end
            MID: begin
                mul_a = sa;
                mul_b = sb;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        mul_out = MW'(mul_a) * MW'(mul_b);
    end

    // Recombination. zm >= z2 + z0 always, so z1 never wraps. The full sum
    // never exceeds 2W bits, so it is formed directly at product width.
    always_comb begin
        z1     = zm - MW'(z2) - MW'(z0);
        p_next = (PW'(z2) << W) + (PW'(z1) << H) + PW'(z0);
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            ah        <= '0;
            al        <= '0;
            bh        <= '0;
            bl        <= '0;
            sa        <= '0;
            sb        <= '0;
            z0        <= '0;
            z2        <= '0;
            zm        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ah       <= a[W-1:H];
                        al       <= a[H-1:0];
                        bh       <= b[W-1:H];
                        bl       <= b[H-1:0];
                        sa       <= HP'(a[W-1:H]) + HP'(a[H-1:0]);
                        sb       <= HP'(b[W-1:H]) + HP'(b[H-1:0]);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LO;
                    end
                end
                LO: begin
                    z0    <= mul_out[2*H-1:0];
                    state <= HI;
                end
                HI: begin
                    z2    <= mul_out[2*H-1:0];
                    state <= MID;
                end
                MID: begin
                    zm    <= mul_out;
                    state <= COMB;
                end
                COMB: begin
                    p         <= p_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_mul16_seq.sv
// Self-checking bench for karatsuba_mul16_seq: fixed vectors, backpressure,
// asynchronous reset mid-operation, random and back-to-back products.
module tb_karatsuba_mul16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int errors = 0;
    int checks = 0;

    karatsuba_mul16_seq #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    // Reference: the product of two unsigned integers, nothing more.
    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; optionally hold out_ready low for 'hold' cycles
    // after out_valid rises while scribbling on the input side.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp, input int hold, input string tag);
        int cyc;
        int ir_bad;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        chk({tag, "_in_ready_after_accept"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        cyc    = 0;
        ir_bad = 0;
        while (!out_valid && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (in_ready) ir_bad++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd4);
        chk({tag, "_in_ready_low_busy"}, 64'(ir_bad), 64'd0);
        chk({tag, "_p"}, 64'(p), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("%s_hold%0d_p", tag, k), 64'(p), 64'(exp));
            chk($sformatf("%s_hold%0d_ovalid", tag, k), 64'(out_valid), 64'd1);
            chk($sformatf("%s_hold%0d_iready", tag, k), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_dropped"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_busy_cleared"}, 64'(busy), 64'd0);
        chk({tag, "_p_held"}, 64'(p), 64'(exp));
    endtask

    vec_t vecs[5];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] expq[$];
        logic [31:0] e;
        int          nacc;
        int          nout;
        int          cyc;
        int          last_acc;

        vecs[0] = '{a: 16'h1234, b: 16'h5678, p: 32'h06260060};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001};
        vecs[2] = '{a: 16'h0000, b: 16'hABCD, p: 32'h00000000};
        vecs[3] = '{a: 16'h8000, b: 16'h0002, p: 32'h00010000};
        vecs[4] = '{a: 16'h00FF, b: 16'hFF00, p: 32'h00FE0100};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_p", 64'(p), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, $sformatf("vec%0d", i));

        run_op(16'hBEEF, 16'h1357, model(16'hBEEF, 16'h1357), 5, "backpressure");

        // Abort while the middle product is being formed.
        @(negedge clk);
        a        = 16'hC0DE;
        b        = 16'h7777;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_p", 64'(p), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd3, 16'd5, 32'd15, 0, "after_rst");

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, model(ra, rb), 0, $sformatf("rand%0d", i));
        end

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        nacc      = 0;
        nout      = 0;
        cyc       = 0;
        last_acc  = 0;
        while (nout < 8 && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk($sformatf("b2b%0d_p", nout), 64'(p), 64'(e));
                end else begin
                    chk("b2b_unexpected_output", 64'd1, 64'd0);
                end
                nout++;
            end
            if (in_ready && nacc < 8) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                a  = ra;
                b  = rb;
                expq.push_back(model(ra, rb));
                if (nacc > 0) chk($sformatf("b2b%0d_gap", nacc), 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                nacc++;
            end else if (nacc >= 8) begin
                in_valid = 1'b0;
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        chk("b2b_outputs", 64'(nout), 64'd8);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
